// File: rtl/shot_arbiter.sv
// Two-player shot arbiter: trigger edge detect, per-player cooldown, in-flight budget, round-robin grant.
// Optional SHOT_AUTOFIRE_EN: a held trigger re-arms a player straight from the end of cooldown.
module shot_arbiter #(
  parameter int COOLDOWN     = 3000000,
  parameter int CD_W         = 22,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       trig_a,
  input  logic       trig_b,
  input  logic [9:0] pos_x_a,
  input  logic [9:0] pos_x_b,
  input  logic       shot_retired,
  output logic       fire,
  output logic [9:0] fire_x,
  output logic       fire_src,
  output logic [3:0] inflight,
  output logic       pool_full,
  output logic       busy_a,
  output logic       busy_b
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    COOL    = 2'd2
  } state_t;

  state_t          state_q [2];
  state_t          state_d [2];
  logic [CD_W-1:0] cd_q [2];
  logic [CD_W-1:0] cd_d [2];
  logic [1:0]      trig_prev_q, trig_prev_d;
  logic            last_grant_q, last_grant_d;
  logic [3:0]      inflight_q, inflight_d;
  logic            fire_q, fire_d;
  logic [9:0]      fire_x_q, fire_x_d;
  logic            fire_src_q, fire_src_d;

  logic [1:0]      trig;
  logic [1:0]      grant;
  logic            can_grant;
  logic            retire_ok;

  assign trig = {trig_b, trig_a};

  // Index 0 is player A, index 1 is player B; last_grant uses the same encoding.
  always_comb begin
    trig_prev_d  = trig;
    can_grant    = (inflight_q < 4'(MAX_INFLIGHT));
    retire_ok    = shot_retired && (inflight_q != 4'd0);
    grant        = 2'b00;
    last_grant_d = last_grant_q;
    fire_x_d     = fire_x_q;
    fire_src_d   = fire_src_q;
    inflight_d   = inflight_q;

    if (can_grant) begin
      if (state_q[0] == PENDING && (state_q[1] != PENDING || last_grant_q)) begin
        grant = 2'b01;
      end else if (state_q[1] == PENDING) begin
        grant = 2'b10;
      end
    end

    fire_d = |grant;
    if (grant[0]) begin
      fire_x_d     = pos_x_a;
      fire_src_d   = 1'b0;
      last_grant_d = 1'b0;
    end else if (grant[1]) begin
      fire_x_d     = pos_x_b;
      fire_src_d   = 1'b1;
      last_grant_d = 1'b1;
    end

    case ({fire_d, retire_ok})
      2'b10:   inflight_d = inflight_q + 4'd1;
      2'b01:   inflight_d = inflight_q - 4'd1;
      default: inflight_d = inflight_q;
    endcase

    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      cd_d[i]    = cd_q[i];
      case (state_q[i])
        IDLE: begin
          if (trig[i] && !trig_prev_q[i]) state_d[i] = PENDING;
        end
        PENDING: begin
          if (grant[i]) begin
            state_d[i] = COOL;
            cd_d[i]    = CD_W'(COOLDOWN - 1);
          end
        end
        COOL: begin
          if (cd_q[i] == '0) begin
`ifdef SHOT_AUTOFIRE_EN
            state_d[i] = trig[i] ? PENDING : IDLE;
`else
            state_d[i] = IDLE;
`endif
          end else begin
            cd_d[i] = cd_q[i] - CD_W'(1);
          end
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  // Last grant resets to B so that A wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q[0]   <= IDLE;
      state_q[1]   <= IDLE;
      cd_q[0]      <= '0;
      cd_q[1]      <= '0;
      trig_prev_q  <= 2'b00;
      last_grant_q <= 1'b1;
      inflight_q   <= 4'd0;
      fire_q       <= 1'b0;
      fire_x_q     <= 10'd0;
      fire_src_q   <= 1'b0;
    end else begin
      state_q[0]   <= state_d[0];
      state_q[1]   <= state_d[1];
      cd_q[0]      <= cd_d[0];
      cd_q[1]      <= cd_d[1];
      trig_prev_q  <= trig_prev_d;
      last_grant_q <= last_grant_d;
      inflight_q   <= inflight_d;
      fire_q       <= fire_d;
      fire_x_q     <= fire_x_d;
      fire_src_q   <= fire_src_d;
    end
  end

  assign fire      = fire_q;
  assign fire_x    = fire_x_q;
  assign fire_src  = fire_src_q;
  assign inflight  = inflight_q;
  assign pool_full = (inflight_q == 4'(MAX_INFLIGHT));
  assign busy_a    = (state_q[0] != IDLE);
  assign busy_b    = (state_q[1] != IDLE);

endmodule

// File: tb/tb_shot_arbiter.sv
// Directed bench for shot_arbiter with COOLDOWN=8, MAX_INFLIGHT=2.
// Expectations for the held-trigger test switch on SHOT_AUTOFIRE_EN.
module tb_shot_arbiter;

  localparam int COOLDOWN     = 8;
  localparam int CD_W         = 4;
  localparam int MAX_INFLIGHT = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       trig_a = 1'b0;
  logic       trig_b = 1'b0;
  logic [9:0] pos_x_a = 10'd0;
  logic [9:0] pos_x_b = 10'd0;
  logic       shot_retired = 1'b0;
  logic       fire;
  logic [9:0] fire_x;
  logic       fire_src;
  logic [3:0] inflight;
  logic       pool_full;
  logic       busy_a;
  logic       busy_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shot_arbiter #(
    .COOLDOWN(COOLDOWN),
    .CD_W(CD_W),
    .MAX_INFLIGHT(MAX_INFLIGHT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .trig_a(trig_a),
    .trig_b(trig_b),
    .pos_x_a(pos_x_a),
    .pos_x_b(pos_x_b),
    .shot_retired(shot_retired),
    .fire(fire),
    .fire_x(fire_x),
    .fire_src(fire_src),
    .inflight(inflight),
    .pool_full(pool_full),
    .busy_a(busy_a),
    .busy_b(busy_b)
  );

  // Outputs packed as {fire, fire_x, fire_src, inflight, pool_full, busy_a, busy_b}.
  typedef struct {
    string       name;
    logic        ta;
    logic        tb;
    logic        ret;
    logic [9:0]  xa;
    logic [9:0]  xb;
    logic [18:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [18:0] ex(logic f, logic [9:0] fx, logic fs, logic [3:0] inf,
                                     logic full, logic ba, logic bb);
    return {f, fx, fs, inf, full, ba, bb};
  endfunction

  function automatic string fmt(logic [18:0] v);
    return $sformatf("fire=%0d x=%0d src=%0d inflight=%0d full=%0d busy_a=%0d busy_b=%0d",
                     v[18], v[17:8], v[7], v[6:3], v[2], v[1], v[0]);
  endfunction

  function automatic void add(string n, logic ta, logic tb, logic ret, logic [9:0] xa,
                              logic [9:0] xb, logic [18:0] e);
    vecs.push_back('{n, ta, tb, ret, xa, xb, e});
  endfunction

  task automatic apply_stimulus(input logic ta, input logic tb, input logic ret,
                                input logic [9:0] xa, input logic [9:0] xb);
    trig_a       = ta;
    trig_b       = tb;
    shot_retired = ret;
    pos_x_a      = xa;
    pos_x_b      = xb;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [18:0] exp);
    logic [18:0] got;
    got = {fire, fire_x, fire_src, inflight, pool_full, busy_a, busy_b};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got {%s} expected {%s}", name, fmt(got), fmt(exp));
    end
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("[TB] FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic reset_dut();
    reset        = 1'b0;
    trig_a       = 1'b0;
    trig_b       = 1'b0;
    shot_retired = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int fires;
    int last;
    int gap_bad;
    int exp_fires;
    logic ret;

    // Tie after reset (A first), solo A, then tie with last_grant=A (B first).
    add("t2_edge",      1, 1, 0, 100, 200, ex(0,   0, 0, 0, 0, 1, 1));
    add("t2_grant_a",   1, 1, 0, 100, 200, ex(1, 100, 0, 1, 0, 1, 1));
    add("t2_grant_b",   1, 1, 0, 100, 200, ex(1, 200, 1, 2, 1, 1, 1));
    add("t2_retire1",   0, 0, 1, 100, 200, ex(0, 200, 1, 1, 0, 1, 1));
    add("t2_retire2",   0, 0, 1, 100, 200, ex(0, 200, 1, 0, 0, 1, 1));
    for (int i = 0; i < 4; i++)
      add("t2_cool",    0, 0, 0, 100, 200, ex(0, 200, 1, 0, 0, 1, 1));
    add("t2_a_idle",    0, 0, 0, 100, 200, ex(0, 200, 1, 0, 0, 0, 1));
    add("t2_b_idle",    0, 0, 0, 100, 200, ex(0, 200, 1, 0, 0, 0, 0));
    add("solo_edge",    1, 0, 0, 300, 400, ex(0, 200, 1, 0, 0, 1, 0));
    add("solo_fire",    1, 0, 0, 300, 400, ex(1, 300, 0, 1, 0, 1, 0));
    add("solo_retire",  0, 0, 1, 300, 400, ex(0, 300, 0, 0, 0, 1, 0));
    for (int i = 0; i < 6; i++)
      add("solo_cool",  0, 0, 0, 300, 400, ex(0, 300, 0, 0, 0, 1, 0));
    add("solo_idle",    0, 0, 0, 300, 400, ex(0, 300, 0, 0, 0, 0, 0));
    add("tie2_edge",    1, 1, 0, 300, 400, ex(0, 300, 0, 0, 0, 1, 1));
    add("tie2_grant_b", 1, 1, 0, 300, 400, ex(1, 400, 1, 1, 0, 1, 1));
    add("tie2_grant_a", 1, 1, 0, 300, 400, ex(1, 300, 0, 2, 1, 1, 1));
    // Pool full: a rising edge during cooldown is dropped, then a request waits for a retire.
    add("t3_cool",      0, 0, 0, 300, 400, ex(0, 300, 0, 2, 1, 1, 1));
    add("t3_drop_edge", 1, 0, 0, 300, 400, ex(0, 300, 0, 2, 1, 1, 1));
    for (int i = 0; i < 4; i++)
      add("t3_cool",    0, 0, 0, 300, 400, ex(0, 300, 0, 2, 1, 1, 1));
    add("t3_b_idle",    0, 0, 0, 300, 400, ex(0, 300, 0, 2, 1, 1, 0));
    add("t3_a_idle",    0, 0, 0, 300, 400, ex(0, 300, 0, 2, 1, 0, 0));
    add("t3_full_edge", 1, 0, 0, 500, 400, ex(0, 300, 0, 2, 1, 1, 0));
    add("t3_full_wait", 1, 0, 0, 500, 400, ex(0, 300, 0, 2, 1, 1, 0));
    add("t3_full_wait", 1, 0, 0, 500, 400, ex(0, 300, 0, 2, 1, 1, 0));
    add("t3_retire",    1, 0, 1, 500, 400, ex(0, 300, 0, 1, 0, 1, 0));
    add("t3_fire",      1, 0, 0, 500, 400, ex(1, 500, 0, 2, 1, 1, 0));

    $display("[TB] start");
    reset_dut();
    check_output("reset_state", ex(0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].ta, vecs[i].tb, vecs[i].ret, vecs[i].xa, vecs[i].xb);
      check_output($sformatf("%s[%0d]", vecs[i].name, i), vecs[i].exp);
    end

    // Fire and retire resolved on the same edge, then retire at zero.
    reset_dut();
    apply_stimulus(0, 1, 0, 30, 20);
    apply_stimulus(0, 1, 0, 30, 20);
    check_val("t4_b_fire_inflight", int'(inflight), 1);
    apply_stimulus(1, 0, 0, 30, 20);
    apply_stimulus(1, 0, 1, 30, 20);
    check_val("t4_fire_with_retire", int'({fire, fire_x}), int'({1'b1, 10'd30}));
    check_val("t4_inflight_unchanged", int'(inflight), 1);
    apply_stimulus(0, 0, 1, 30, 20);
    check_val("t4_retire_to_zero", int'(inflight), 0);
    apply_stimulus(0, 0, 1, 30, 20);
    check_val("t4_no_underflow", int'({inflight, pool_full}), 0);

    // Trigger held for 40 clocks with each shot retired right after launch.
    reset_dut();
    fires   = 0;
    last    = -1;
    gap_bad = 0;
    ret     = 1'b0;
    for (int s = 1; s <= 40; s++) begin
      apply_stimulus(1, 0, ret, 77, 0);
      if (fire) begin
        if (last >= 0 && (s - last) != COOLDOWN + 1) gap_bad++;
        last = s;
        fires++;
      end
      ret = fire;
    end
`ifdef SHOT_AUTOFIRE_EN
    exp_fires = 5;
`else
    exp_fires = 1;
`endif
    check_val("t5_fire_count", fires, exp_fires);
    check_val("t5_fire_spacing", gap_bad, 0);

    // Asynchronous reset while B waits on a full pool.
    reset_dut();
    apply_stimulus(1, 1, 0, 40, 50);
    apply_stimulus(1, 1, 0, 40, 50);
    apply_stimulus(1, 1, 0, 40, 50);
    for (int i = 0; i < 9; i++) apply_stimulus(0, 0, 0, 40, 50);
    apply_stimulus(0, 1, 0, 40, 50);
    apply_stimulus(0, 1, 0, 40, 50);
    check_output("t6_b_pending_full", ex(0, 50, 1, 2, 1, 0, 1));
    #3;
    reset  = 1'b0;
    trig_b = 1'b0;
    #1;
    check_output("t6_async_reset", ex(0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    fires = 0;
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(0, 0, 0, 40, 50);
      if (fire || busy_a || busy_b) fires++;
    end
    check_val("t6_quiet_after_release", fires, 0);
    apply_stimulus(0, 1, 0, 40, 50);
    apply_stimulus(0, 1, 0, 40, 50);
    check_output("t6_new_edge_fires", ex(1, 50, 1, 1, 0, 0, 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
